seg_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for the 4-digit 7-segment display on the lab board. It owns the single hex-to-segment decoder and shares it across four digits. Each digit slot presents one nibble to the decoder, registers the returned segment pattern and enables one common anode. New display values are double-buffered and committed only at frame boundaries, so the display never shows a half-updated value.

---
 rtl/seg_scan_ctrl.sv | 143 ++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl
//   Time-multiplexed scan controller for a 4-digit common-anode 7-segment
//   display. One shared hex decoder (external, combinational) is fed one
//   nibble per digit slot. The returned pattern is registered to the pins.
//   Display data is double-buffered: writes land in a shadow register and
//   are committed to the active register only at a frame boundary.
//
// Parameters
//   DIV    clock cycles per digit slot (DIV > BLANK + 1)
//   BLANK  cycles at slot start with every anode off (BLANK >= 2)
//
// Ports
//   clk         system clock, rising edge
//   rst         synchronous, active-high reset
//   wr_en       one-cycle strobe, captures value_in/dots_in into the shadow
//   value_in    four hex digits, [3:0] is digit 0 (rightmost)
//   dots_in     per-digit decimal point, 1 = lit
//   seg_in      active-low segment pattern from the decoder for nib
//   nib         nibble presented to the decoder
//   led         registered pins: [7] active-low dot, [6:0] segments
//   an          active-low anode enables, at most one low
//   pending     shadow holds data not yet committed
//   frame_tick  one-cycle pulse in the cycle the active register updates
//
// Build option
//   SEG_LZB_EN  when defined, leading-zero digits (above digit 0) keep
//               their anode off for the whole slot.

module seg_scan_ctrl #(
    parameter int DIV   = 50000,
    parameter int BLANK = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [15:0] value_in,
    input  logic [3:0]  dots_in,
    input  logic [6:0]  seg_in,
    output logic [3:0]  nib,
    output logic [7:0]  led,
    output logic [3:0]  an,
    output logic        pending,
    output logic        frame_tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nx;
    logic [1:0]    idx;
    logic [1:0]    idx_nx;
    logic [15:0]   act_val;
    logic [15:0]   act_val_nx;
    logic [3:0]    act_dots;
    logic [3:0]    act_dots_nx;
    logic [15:0]   shd_val;
    logic [3:0]    shd_dots;
    logic          dot_latched;
    logic          slot_end;
    logic          commit;
    logic          hide;
    logic [3:0]    nib_nx;
    logic [3:0]    an_nx;

    // Everything is computed from the values the registers take at the next
    // edge, so nib/an/led line up with cnt and the commit lands exactly at
    // the start of digit 0 of the new frame.
    always_comb begin
        slot_end    = (cnt == CW'(DIV - 1));
        commit      = slot_end && (idx == 2'd3) && pending;
        cnt_nx      = slot_end ? '0 : cnt + 1'b1;
        idx_nx      = slot_end ? idx + 2'd1 : idx;
        act_val_nx  = commit ? shd_val  : act_val;
        act_dots_nx = commit ? shd_dots : act_dots;

        nib_nx = 4'h0;
        unique case (idx_nx)
            2'd0: nib_nx = act_val_nx[3:0];
            2'd1: nib_nx = act_val_nx[7:4];
            2'd2: nib_nx = act_val_nx[11:8];
            2'd3: nib_nx = act_val_nx[15:12];
        endcase

        hide = 1'b0;
`ifdef SEG_LZB_EN
        // A digit is a leading zero when it and every digit above it are 0.
        // Digit 0 is always shown; dots play no part in this.
        unique case (idx_nx)
            2'd0: hide = 1'b0;
            2'd1: hide = (act_val_nx[15:4]  == 12'h000);
            2'd2: hide = (act_val_nx[15:8]  == 8'h00);
            2'd3: hide = (act_val_nx[15:12] == 4'h0);
        endcase
`endif

        if (cnt_nx < CW'(BLANK) || hide)
            an_nx = 4'b1111;
        else
            an_nx = ~(4'b0001 << idx_nx);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            idx         <= 2'd0;
            act_val     <= 16'h0000;
            act_dots    <= 4'h0;
            shd_val     <= 16'h0000;
            shd_dots    <= 4'h0;
            pending     <= 1'b0;
            nib         <= 4'h0;
            dot_latched <= 1'b0;
            led         <= 8'hFF;
            an          <= 4'b1111;
            frame_tick  <= 1'b0;
        end else begin
            cnt        <= cnt_nx;
            idx        <= idx_nx;
            act_val    <= act_val_nx;
            act_dots   <= act_dots_nx;
            frame_tick <= commit;
            an         <= an_nx;

            // A write on the commit cycle goes to the shadow after the old
            // shadow has been copied out, so pending stays set.
            if (wr_en) begin
                shd_val  <= value_in;
                shd_dots <= dots_in;
                pending  <= 1'b1;
            end else if (commit) begin
                pending  <= 1'b0;
            end

            if (slot_end) begin
                nib         <= nib_nx;
                dot_latched <= act_dots_nx[idx_nx];
            end

            led <= {~dot_latched, seg_in};
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl with DIV = 8, BLANK = 2. A reference hex decoder
// drives seg_in. Each write pushes the frame it should produce onto a
// scoreboard queue (or overwrites the still-uncommitted tail); each
// frame_tick pops one entry and the following frame is compared slot by slot.

module tb_seg_scan_ctrl;

    localparam int DIV   = 8;
    localparam int BLANK = 2;

    typedef struct {
        logic [15:0] v;
        logic [3:0]  d;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic [15:0] value_in;
    logic [3:0]  dots_in;
    logic [6:0]  seg_in;
    logic [3:0]  nib;
    logic [7:0]  led;
    logic [3:0]  an;
    logic        pending;
    logic        frame_tick;

    int   vectors = 0;
    int   miscompares = 0;
    exp_t q[$];

    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'h0: seg7 = 7'b1000000;
            4'h1: seg7 = 7'b1111001;
            4'h2: seg7 = 7'b0100100;
            4'h3: seg7 = 7'b0110000;
            4'h4: seg7 = 7'b0011001;
            4'h5: seg7 = 7'b0010010;
            4'h6: seg7 = 7'b0000010;
            4'h7: seg7 = 7'b1111000;
            4'h8: seg7 = 7'b0000000;
            4'h9: seg7 = 7'b0010000;
            4'hA: seg7 = 7'b0001000;
            4'hB: seg7 = 7'b0000011;
            4'hC: seg7 = 7'b1000110;
            4'hD: seg7 = 7'b0100001;
            4'hE: seg7 = 7'b0000110;
            default: seg7 = 7'b0001110;
        endcase
    endfunction

    // Anode pattern expected during the SHOW phase of digit i.
    function automatic logic [3:0] exp_an(input logic [15:0] v, input int i);
        logic [3:0] a;
        a = ~(4'b0001 << i);
`ifdef SEG_LZB_EN
        if (i > 0 && (v >> (4 * i)) == 16'h0000)
            a = 4'b1111;
`endif
        return a;
    endfunction

    assign seg_in = seg7(nib);

    seg_scan_ctrl #(.DIV(DIV), .BLANK(BLANK)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .value_in   (value_in),
        .dots_in    (dots_in),
        .seg_in     (seg_in),
        .nib        (nib),
        .led        (led),
        .an         (an),
        .pending    (pending),
        .frame_tick (frame_tick)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no end of run, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drives one write in the cycle after the current negedge.
    task automatic do_write(input logic [15:0] v, input logic [3:0] d, input bit collide);
        exp_t e;
        @(negedge clk);
        wr_en    = 1'b1;
        value_in = v;
        dots_in  = d;
        e.v = v;
        e.d = d;
        if (q.size() != 0 && !collide)
            q[q.size() - 1] = e;
        else
            q.push_back(e);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic wait_tick(output exp_t e);
        int k;
        k = 0;
        while (frame_tick !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("frame_tick_seen", {15'h0, frame_tick}, 16'h1);
        chk("sb_nonempty", {15'h0, q.size() != 0}, 16'h1);
        if (q.size() != 0) begin
            e = q.pop_front();
        end else begin
            e.v = 16'h0000;
            e.d = 4'h0;
        end
    endtask

    // Starts at the negedge of cycle 0 of a frame and ends at cycle 31.
    task automatic check_frame(input exp_t e);
        logic [3:0] n;
        for (int i = 0; i < 4; i++) begin
            n = 4'((e.v >> (4 * i)) & 16'h000F);
            for (int c = 0; c < DIV; c++) begin
                if (!(i == 0 && c == 0))
                    @(negedge clk);
                if (c == 0)
                    chk($sformatf("nib d%0d v%h", i, e.v), {12'h0, nib}, {12'h0, n});
                chk($sformatf("an d%0d c%0d v%h", i, c, e.v), {12'h0, an},
                    {12'h0, (c < BLANK) ? 4'b1111 : exp_an(e.v, i)});
                if (c >= 1)
                    chk($sformatf("led d%0d c%0d v%h", i, c, e.v), {8'h0, led},
                        {8'h0, ~e.d[i], seg7(n)});
            end
        end
    endtask

    initial begin
        exp_t e;
        rst      = 1'b1;
        wr_en    = 1'b0;
        value_in = 16'h0000;
        dots_in  = 4'h0;

        // Reset
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_an", {12'h0, an}, 16'h000F);
        chk("rst_led", {8'h0, led}, 16'h00FF);
        chk("rst_pending", {15'h0, pending}, 16'h0);
        chk("rst_nib", {12'h0, nib}, 16'h0);
        chk("rst_tick", {15'h0, frame_tick}, 16'h0);
        @(negedge clk);
        chk("rst_an_c1", {12'h0, an}, 16'h000F);
        @(negedge clk);
        chk("rst_an_c2", {12'h0, an}, 16'h000E);

        // Scan
        do_write(16'h1234, 4'b0000, 1'b0);
        chk("scan_pending", {15'h0, pending}, 16'h1);
        wait_tick(e);
        chk("scan_pending_clr", {15'h0, pending}, 16'h0);
        check_frame(e);

        // Double buffer: last write wins, one tick only
        do_write(16'hAAAA, 4'b0000, 1'b0);
        do_write(16'h5555, 4'b0000, 1'b0);
        chk("dbuf_pending", {15'h0, pending}, 16'h1);
        wait_tick(e);
        check_frame(e);
        @(negedge clk);
        chk("dbuf_no_2nd_tick", {15'h0, frame_tick}, 16'h0);
        chk("dbuf_pending_clr", {15'h0, pending}, 16'h0);
        check_frame(e);

        // Collision: second write lands on the commit cycle
        do_write(16'h1357, 4'b0000, 1'b0);
        repeat (29) @(negedge clk);
        do_write(16'hBEEF, 4'b0000, 1'b1);
        wait_tick(e);
        chk("coll_pending", {15'h0, pending}, 16'h1);
        check_frame(e);
        @(negedge clk);
        wait_tick(e);
        chk("coll_pending_clr", {15'h0, pending}, 16'h0);
        check_frame(e);

        // Dots, then reset in the middle of digit 2 SHOW
        do_write(16'h9876, 4'b0101, 1'b0);
        wait_tick(e);
        check_frame(e);
        repeat (21) @(negedge clk);
        chk("mid_an_d2", {12'h0, an}, {12'h0, exp_an(16'h9876, 2)});
        rst = 1'b1;
        @(negedge clk);
        q.delete();
        chk("mid_rst_an", {12'h0, an}, 16'h000F);
        chk("mid_rst_nib", {12'h0, nib}, 16'h0);
        chk("mid_rst_led", {8'h0, led}, 16'h00FF);
        chk("mid_rst_pending", {15'h0, pending}, 16'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("mid_rel_an_c0", {12'h0, an}, 16'h000F);
        repeat (2) @(negedge clk);
        chk("mid_rel_an_c2", {12'h0, an}, 16'h000E);

        // Leading zeros
        do_write(16'h0030, 4'b0000, 1'b0);
        wait_tick(e);
        check_frame(e);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
